// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the 1-to-4 TDM demultiplexer.
package tdm_pkg;

  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/demux_1_to_4.sv
// demux_1_to_4: 2-to-4 one-hot decoder with enable; selects which slot
// register captures the current beat.
module demux_1_to_4
  import tdm_pkg::*;
(
  input  logic             en,
  input  slot_t            sel,
  output logic [SLOTS-1:0] onehot
);

  // one-hot decode of the slot index, all-zero when not enabled
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux_1_to_4.sv
// tdm_demux_1_to_4: 1-to-4 TDM frame demultiplexer with frame_sync lock.
// Slots 0..2 collect in shadow registers; the slot-3 beat loads the whole
// frame into Y on the same edge so Y never shows a partial frame.
// Optional build macro TDM_DEMUX_ERR_CNT_EN adds an 8-bit saturating
// err_cnt output counting sync errors and lock losses.
module tdm_demux_1_to_4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   frame_sync,
  output logic [SLOTS*WIDTH-1:0] Y,
  output logic                   frame_valid,
  output logic [SLOT_W-1:0]      slot,
  output logic                   locked,
  output logic                   sync_err
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]             err_cnt
`endif
);

  state_t state_q, state_d;
  slot_t  slot_q, slot_d;
  logic   fv_d, se_d;
  logic   wr_en;
  slot_t  wr_idx;
  logic [SLOTS-1:0]             wr_sel;
  logic [SLOTS-2:0][WIDTH-1:0]  shadow_q;

  // next-state / slot / pulse decode for one beat
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = slot_q;
    if (din_valid) begin
      if (frame_sync) begin
        // sync always restarts a frame at slot 0; mid-frame sync is an error
        se_d    = (state_q == LOCKED) && (slot_q != '0);
        state_d = LOCKED;
        slot_d  = slot_t'(1);
        wr_en   = 1'b1;
        wr_idx  = '0;
      end else if (state_q == LOCKED) begin
        if (slot_q == '0) begin
          // slot 0 without sync means framing was lost
          state_d = HUNT;
        end else begin
          wr_en  = 1'b1;
          slot_d = slot_q + 1'b1;
          fv_d   = (slot_q == slot_t'(SLOTS-1));
        end
      end
    end
  end

  demux_1_to_4 u_dec (
    .en     (wr_en),
    .sel    (wr_idx),
    .onehot (wr_sel)
  );

  // FSM state, slot index and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      frame_valid <= fv_d;
      sync_err    <= se_d;
    end
  end

  // shadow capture of slots 0..2 and atomic frame load on the slot-3 beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      Y        <= '0;
    end else begin
      for (int k = 0; k < SLOTS-1; k++)
        if (wr_sel[k]) shadow_q[k] <= din;
      if (wr_sel[SLOTS-1]) Y <= {din, shadow_q};
    end
  end

  assign slot   = slot_q;
  assign locked = (state_q == LOCKED);

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic err_evt;
  assign err_evt = se_d ||
                   (din_valid && !frame_sync && state_q == LOCKED && slot_q == '0);

  // saturating count of sync errors and lock losses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_cnt <= '0;
    else if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// tb_tdm_demux_1_to_4: scoreboard bench; expected frames are queued as
// stimulus is driven and compared whenever frame_valid is seen.
module tb_tdm_demux_1_to_4;

  localparam int WIDTH = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid, frame_sync;
  logic [4*WIDTH-1:0] Y;
  logic             frame_valid;
  logic [1:0]       slot;
  logic             locked, sync_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0]       err_cnt;
`endif

  always #5 clk = ~clk;

  tdm_demux_1_to_4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .Y           (Y),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int fv_cnt = 0;
  int se_cnt = 0;
  logic [3:0] exp_q[$];
  int         fv_cyc[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // scoreboard monitor: every frame_valid cycle consumes one expected frame
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sync_err === 1'b1) se_cnt++;
      if (frame_valid === 1'b1) begin
        fv_cnt++;
        fv_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("fv_spurious", 32'd1, 32'd0);
        else                   chk("frame_y", 32'(Y), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic d, input logic fs);
    din        = d;
    frame_sync = fs;
    din_valid  = 1'b1;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = '0;
  endtask

  task automatic send_frame(input logic [3:0] bits, input bit gap);
    exp_q.push_back(bits);
    for (int k = 0; k < 4; k++) begin
      beat(bits[k], k == 0);
      if (gap && k < 3) idle(1);
    end
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    idle(2);
    chk("rst_y",      32'(Y), 32'd0);
    chk("rst_fv",     32'(frame_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_slot",   32'(slot), 32'd0);
    chk("rst_se",     32'(sync_err), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // beats without sync in HUNT are dropped
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    idle(1);
    chk("hunt_y",      32'(Y), 32'd0);
    chk("hunt_slot",   32'(slot), 32'd0);
    chk("hunt_locked", 32'(locked), 32'd0);
    chk("hunt_fv",     32'(fv_cnt), 32'd0);

    // first frame 1,0,1,1
    send_frame(4'b1101, 1'b0);
    chk("f1_fv",     32'(frame_valid), 32'd1);
    chk("f1_y",      32'(Y), 32'hD);
    chk("f1_locked", 32'(locked), 32'd1);
    idle(1);
    chk("f1_fv_off", 32'(frame_valid), 32'd0);
    chk("f1_slot",   32'(slot), 32'd0);

    // back-to-back frames
    send_frame(4'b0001, 1'b0);
    send_frame(4'b1110, 1'b0);
    idle(1);
    chk("b2b_cnt", 32'(fv_cnt), 32'd3);
    if (fv_cyc.size() >= 2)
      chk("b2b_gap", 32'(fv_cyc[fv_cyc.size()-1] - fv_cyc[fv_cyc.size()-2]), 32'd4);
    else
      chk("b2b_gap_missing", 32'(fv_cyc.size()), 32'd2);

    // misplaced sync at slot 2
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    chk("se_pre_slot", 32'(slot), 32'd2);
    exp_q.push_back(4'b0110);
    beat(1'b0, 1'b1);
    chk("se_pulse",  32'(sync_err), 32'd1);
    chk("se_locked", 32'(locked), 32'd1);
    chk("se_slot",   32'(slot), 32'd1);
    beat(1'b1, 1'b0);
    chk("se_pulse_off", 32'(sync_err), 32'd0);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    idle(1);
    chk("se_cnt",    32'(se_cnt), 32'd1);
    chk("se_fv_cnt", 32'(fv_cnt), 32'd4);
`ifdef TDM_DEMUX_ERR_CNT_EN
    chk("se_err_cnt", 32'(err_cnt), 32'd1);
`endif

    // idle gaps between every beat
    send_frame(4'b1011, 1'b1);
    idle(2);
    chk("gap_fv_cnt", 32'(fv_cnt), 32'd5);
    chk("gap_y",      32'(Y), 32'hB);

    // slot 0 without sync drops lock
    beat(1'b1, 1'b0);
    idle(1);
    chk("drop_locked", 32'(locked), 32'd0);
    chk("drop_slot",   32'(slot), 32'd0);
    chk("drop_se",     32'(se_cnt), 32'd1);
`ifdef TDM_DEMUX_ERR_CNT_EN
    chk("drop_err_cnt", 32'(err_cnt), 32'd2);
`endif

    // reset after slot 2, then a fresh frame
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_y",      32'(Y), 32'd0);
    chk("mrst_fv",     32'(frame_valid), 32'd0);
    chk("mrst_locked", 32'(locked), 32'd0);
    chk("mrst_slot",   32'(slot), 32'd0);
`ifdef TDM_DEMUX_ERR_CNT_EN
    chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    idle(2);
    rst_n = 1'b1;
    beat(1'b1, 1'b0);
    chk("post_rst_slot",   32'(slot), 32'd0);
    chk("post_rst_locked", 32'(locked), 32'd0);
    send_frame(4'b1001, 1'b0);
    idle(2);
    chk("final_fv_cnt", 32'(fv_cnt), 32'd6);
    chk("final_y",      32'(Y), 32'h9);
    chk("queue_empty",  32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
